// File: rtl/mmio_pkg.sv
// mmio_pkg
// Shared definitions for the memory-mapped I/O hub: access-type codes on
// mmap_sel, register byte offsets, the per-channel register stride and the
// channel handshake state type.
// No ports (package).
package mmio_pkg;

    localparam logic [2:0] SEL_LOAD  = 3'd1;
    localparam logic [2:0] SEL_STORE = 3'd2;
    localparam logic [2:0] SEL_NOP   = 3'd6;

    localparam logic [15:0] ADDR_CYCLE     = 16'h0010;
    localparam logic [15:0] ADDR_INSTR     = 16'h0014;
    localparam logic [15:0] ADDR_CLEAR     = 16'h0018;
    localparam logic [15:0] ADDR_FIFO_STAT = 16'h0020;
    localparam logic [15:0] ADDR_FIFO_POP  = 16'h0024;
    localparam logic [15:0] ADDR_SWITCH    = 16'h0028;
    localparam logic [15:0] ADDR_LED       = 16'h0030;
    localparam logic [15:0] ADDR_CH_DUTY   = 16'h0100;
    localparam logic [15:0] ADDR_CH_STAT   = 16'h0104;

    localparam int CH_STRIDE = 8;

    typedef enum logic [1:0] {
        CH_IDLE = 2'd0,
        CH_REQ  = 2'd1,
        CH_DROP = 2'd2
    } ch_state_t;

    // Byte address of a per-channel register given its channel-0 offset.
    function automatic logic [15:0] ch_addr(input logic [15:0] base, input int ch);
        return base + 16'(ch * CH_STRIDE);
    endfunction

endpackage

// File: rtl/event_fifo.sv
// event_fifo
// Synchronous FIFO holding captured event words.
// Ports:
//   clk, rst        clock and synchronous active-low reset
//   push, din       write request and data
//   pop             read request (advances the head)
//   dout            head entry; when empty it forwards din so that a push
//                   and pop in the same cycle on an empty FIFO pass through
//   count           number of stored entries (0..DEPTH)
//   full, empty     occupancy flags
module event_fifo
    import mmio_pkg::*;
#(
    parameter int W     = 3,
    parameter int DEPTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          bypass;
    logic          do_push;
    logic          do_pop;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    // On an empty FIFO a simultaneous push/pop hands din straight to the
    // reader and stores nothing; on a full FIFO the pop frees the slot the
    // push writes into.
    assign bypass  = empty & push & pop;
    assign do_pop  = pop & ~empty;
    assign do_push = push & ~bypass & (~full | pop);
    assign dout    = empty ? din : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst && do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/mmio_hub.sv
// mmio_hub
// Memory-mapped peripheral hub: cycle/instruction counters, event FIFO,
// LED register, switch readback and NUM_CH duty-cycle channels that hand
// each new duty value to a consumer over a four-phase req/ack handshake.
// Ports:
//   clk, rst        clock and synchronous active-low reset
//   en              access qualifier
//   addr, mmap_sel  byte offset and access type (LOAD/STORE/NOP)
//   wdata, rdata    store data in, registered load data out (latency 1)
//   leds            LED register
//   switches        switch inputs
//   events          event levels; any rising bit pushes events into the FIFO
//   duty            per-channel duty values, channel c at [c*DW +: DW]
//   req, ack        per-channel four-phase handshake
module mmio_hub
    import mmio_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int DW         = 12,
    parameter int FIFO_DEPTH = 32,
    parameter int EV_W       = 3,
    parameter int LED_W      = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [15:0]          addr,
    input  logic [2:0]           mmap_sel,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    output logic [LED_W-1:0]     leds,
    input  logic [1:0]           switches,
    input  logic [EV_W-1:0]      events,
    output logic [NUM_CH*DW-1:0] duty,
    output logic [NUM_CH-1:0]    req,
    input  logic [NUM_CH-1:0]    ack
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic        is_load;
    logic        is_store;
    logic        cnt_clear;
    logic [31:0] cyc_cnt;
    logic [31:0] ins_cnt;
    logic [31:0] cyc_nxt;
    logic [31:0] ins_nxt;

    logic [EV_W-1:0] ev_prev;
    logic            ev_push;
    logic            pop_req;
    logic [EV_W-1:0] fifo_dout;
    logic [CW-1:0]   fifo_count;
    logic [8:0]      fifo_cnt9;
    logic            fifo_full;
    logic            fifo_empty;
    logic            ovf;
    logic            ovf_set;
    logic            ovf_clr;
    logic [31:0]     pop_val;

    logic [DW-1:0]     ch_duty [NUM_CH];
    logic [NUM_CH-1:0] ch_busy;
    logic [NUM_CH-1:0] ch_err;
    logic [31:0]       rd_val;
    logic              unused_bits;

    assign is_load  = en && (mmap_sel == SEL_LOAD);
    assign is_store = en && (mmap_sel == SEL_STORE);

    // Counter next values double as the load data, so a load of a counter
    // reports the count including the cycle of the load itself.
    assign cnt_clear = is_store && (addr == ADDR_CLEAR);
    assign cyc_nxt   = cnt_clear ? 32'd0 : cyc_cnt + 32'd1;
    assign ins_nxt   = cnt_clear ? 32'd0 : ins_cnt + 32'(en && (mmap_sel != SEL_NOP));

    always_ff @(posedge clk) begin
        if (!rst) begin
            cyc_cnt <= '0;
            ins_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_nxt;
            ins_cnt <= ins_nxt;
        end
    end

    assign ev_push = |(events & ~ev_prev);
    assign pop_req = is_load && (addr == ADDR_FIFO_POP);

    event_fifo #(
        .W     (EV_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ev_push),
        .pop   (pop_req),
        .din   (events),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // The status field has 8 count bits; a 256-deep FIFO that is full
    // therefore reads count 0 with empty clear.
    assign fifo_cnt9 = 9'(fifo_count);
    assign pop_val   = (fifo_empty && !ev_push) ? 32'd0 : 32'(fifo_dout);

    // A same-cycle pop makes room, so only an unaccompanied push to a full
    // FIFO is an overflow; a new overflow wins over a clear.
    assign ovf_set = ev_push && fifo_full && !pop_req;
    assign ovf_clr = is_store && (addr == ADDR_FIFO_STAT) && wdata[9];

    always_ff @(posedge clk) begin
        if (!rst) begin
            ev_prev <= events;
            ovf     <= 1'b0;
            leds    <= '0;
        end else begin
            ev_prev <= events;
            ovf     <= ovf_set | (ovf & ~ovf_clr);
            if (is_store && (addr == ADDR_LED)) begin
                leds <= wdata[LED_W-1:0];
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        ch_state_t     state;
        logic [DW-1:0] duty_q;
        logic          req_q;
        logic          err_q;
        logic          duty_hit;
        logic          stat_clr;

        assign duty_hit = is_store && (addr == ch_addr(ADDR_CH_DUTY, c));
        assign stat_clr = is_store && (addr == ch_addr(ADDR_CH_STAT, c)) && wdata[1];

        // Duty is only latched from IDLE so the consumer sees a stable
        // value for the whole handshake; stores arriving later are flagged.
        always_ff @(posedge clk) begin
            if (!rst) begin
                state  <= CH_IDLE;
                duty_q <= '0;
                req_q  <= 1'b0;
                err_q  <= 1'b0;
            end else begin
                case (state)
                    CH_IDLE: begin
                        if (duty_hit) begin
                            duty_q <= wdata[DW-1:0];
                            req_q  <= 1'b1;
                            state  <= CH_REQ;
                        end
                    end
                    CH_REQ: begin
                        if (ack[c]) begin
                            req_q <= 1'b0;
                            state <= CH_DROP;
                        end
                    end
                    CH_DROP: begin
                        if (!ack[c]) begin
                            state <= CH_IDLE;
                        end
                    end
                    default: begin
                        req_q <= 1'b0;
                        state <= CH_IDLE;
                    end
                endcase

                if (duty_hit && (state != CH_IDLE)) begin
                    err_q <= 1'b1;
                end else if (stat_clr) begin
                    err_q <= 1'b0;
                end
            end
        end

        assign ch_duty[c]         = duty_q;
        assign ch_busy[c]         = (state != CH_IDLE);
        assign ch_err[c]          = err_q;
        assign duty[c*DW +: DW]   = duty_q;
        assign req[c]             = req_q;
    end

    always_comb begin
        rd_val = '0;
        case (addr)
            ADDR_CYCLE:     rd_val = cyc_nxt;
            ADDR_INSTR:     rd_val = ins_nxt;
            ADDR_FIFO_STAT: rd_val = {22'd0, ovf, fifo_cnt9[7:0], fifo_empty};
            ADDR_FIFO_POP:  rd_val = pop_val;
            ADDR_SWITCH:    rd_val = {30'd0, switches};
            ADDR_LED:       rd_val = 32'(leds);
            default:        rd_val = '0;
        endcase
        for (int c = 0; c < NUM_CH; c++) begin
            if (addr == ch_addr(ADDR_CH_DUTY, c)) begin
                rd_val = 32'(ch_duty[c]);
            end
            if (addr == ch_addr(ADDR_CH_STAT, c)) begin
                rd_val = {30'd0, ch_err[c], ch_busy[c]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata <= '0;
        end else if (is_load) begin
            rdata <= rd_val;
        end
    end

    assign unused_bits = ^{wdata, fifo_cnt9};

endmodule

// File: tb/tb_mmio_hub.sv
module tb_mmio_hub;

    localparam int NUM_CH = 2;
    localparam int DW     = 12;
    localparam int DEPTH  = 4;
    localparam int EV_W   = 3;
    localparam int LED_W  = 6;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en;
    logic [15:0]          addr;
    logic [2:0]           mmap_sel;
    logic [31:0]          wdata;
    logic [31:0]          rdata;
    logic [LED_W-1:0]     leds;
    logic [1:0]           switches;
    logic [EV_W-1:0]      events;
    logic [NUM_CH*DW-1:0] duty;
    logic [NUM_CH-1:0]    req;
    logic [NUM_CH-1:0]    ack;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    mmio_hub #(
        .NUM_CH     (NUM_CH),
        .DW         (DW),
        .FIFO_DEPTH (DEPTH),
        .EV_W       (EV_W),
        .LED_W      (LED_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .addr     (addr),
        .mmap_sel (mmap_sel),
        .wdata    (wdata),
        .rdata    (rdata),
        .leds     (leds),
        .switches (switches),
        .events   (events),
        .duty     (duty),
        .req      (req),
        .ack      (ack)
    );

    typedef struct {
        logic        e;
        logic [2:0]  sel;
        logic [15:0] a;
        logic [31:0] d;
        logic        chk;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    // Reference model state
    int unsigned     mCyc;
    int unsigned     mIns;
    bit              mOvf;
    logic [EV_W-1:0] mQ[$];
    logic [EV_W-1:0] mEvPrev;
    logic [LED_W-1:0] mLeds;
    logic [DW-1:0]   mDuty [NUM_CH];
    bit              mBusy [NUM_CH];
    bit              mReq  [NUM_CH];
    bit              mErr  [NUM_CH];
    logic [31:0]     mRdata;

    logic [15:0] addrPool [14] = '{16'h0010, 16'h0014, 16'h0018, 16'h0020,
                                   16'h0024, 16'h0024, 16'h0028, 16'h0030,
                                   16'h0100, 16'h0104, 16'h0108, 16'h010C,
                                   16'h0110, 16'h0040};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic e, input logic [2:0] sel, input logic [15:0] a,
                                 input logic [31:0] d);
        en       = e;
        mmap_sel = sel;
        addr     = a;
        wdata    = d;
        tick();
        en       = 1'b0;
        mmap_sel = 3'd0;
        addr     = 16'd0;
        wdata    = 32'd0;
    endtask

    task automatic doReset();
        en       = 1'b0;
        mmap_sel = 3'd0;
        addr     = 16'd0;
        wdata    = 32'd0;
        ack      = '0;
        rst      = 1'b0;
        tick();
        rst      = 1'b1;
    endtask

    function automatic vec_t mkVec(input logic e, input logic [2:0] sel, input logic [15:0] a,
                                   input logic [31:0] d, input logic chk, input logic [31:0] exp,
                                   input string name);
        vec_t v;
        v.e = e; v.sel = sel; v.a = a; v.d = d; v.chk = chk; v.exp = exp; v.name = name;
        return v;
    endfunction

    task automatic modelReset();
        mCyc    = 0;
        mIns    = 0;
        mOvf    = 0;
        mQ.delete();
        mEvPrev = events;
        mLeds   = '0;
        mRdata  = 32'd0;
        for (int c = 0; c < NUM_CH; c++) begin
            mDuty[c] = '0;
            mBusy[c] = 0;
            mReq[c]  = 0;
            mErr[c]  = 0;
        end
    endtask

    // Predicts the effect of the coming clock edge from the current inputs.
    task automatic modelStep();
        bit          ld, st, rise, ovfSet;
        logic [31:0] rv;
        bit          preBusy [NUM_CH];
        if (!rst) begin
            modelReset();
            return;
        end
        ld = en && (mmap_sel == 3'd1);
        st = en && (mmap_sel == 3'd2);
        mCyc = mCyc + 1;
        if (en && (mmap_sel != 3'd6)) mIns = mIns + 1;
        if (st && addr == 16'h0018) begin
            mCyc = 0;
            mIns = 0;
        end
        rise    = (events & ~mEvPrev) != 0;
        mEvPrev = events;

        rv = 32'd0;
        if (addr == 16'h0010) rv = mCyc;
        if (addr == 16'h0014) rv = mIns;
        if (addr == 16'h0020) rv = (32'(mOvf) << 9) | (32'(mQ.size()) << 1) | 32'(mQ.size() == 0);
        if (addr == 16'h0028) rv = 32'(switches);
        if (addr == 16'h0030) rv = 32'(mLeds);
        for (int c = 0; c < NUM_CH; c++) begin
            if (addr == 16'h0100 + 16'(8 * c)) rv = 32'(mDuty[c]);
            if (addr == 16'h0104 + 16'(8 * c)) rv = {30'd0, mErr[c], mBusy[c]};
        end

        ovfSet = 0;
        if (ld && addr == 16'h0024) begin
            if (mQ.size() > 0) begin
                rv = 32'(mQ.pop_front());
                if (rise) mQ.push_back(events);
            end else if (rise) begin
                rv = 32'(events);
            end else begin
                rv = 32'd0;
            end
        end else if (rise) begin
            if (mQ.size() < DEPTH) mQ.push_back(events);
            else ovfSet = 1;
        end
        mOvf = ovfSet || (mOvf && !(st && addr == 16'h0020 && wdata[9]));

        if (st && addr == 16'h0030) mLeds = wdata[LED_W-1:0];

        for (int c = 0; c < NUM_CH; c++) begin
            preBusy[c] = mBusy[c];
            if (mBusy[c]) begin
                if (mReq[c] && ack[c]) mReq[c] = 0;
                else if (!mReq[c] && !ack[c]) mBusy[c] = 0;
            end
            if (st && addr == 16'h0100 + 16'(8 * c)) begin
                if (preBusy[c]) begin
                    mErr[c] = 1;
                end else begin
                    mDuty[c] = wdata[DW-1:0];
                    mBusy[c] = 1;
                    mReq[c]  = 1;
                end
            end else if (st && addr == 16'h0104 + 16'(8 * c) && wdata[1]) begin
                mErr[c] = 0;
            end
        end

        if (ld) mRdata = rv;
    endtask

    initial begin
        logic [31:0] v;
        switches = 2'b10;
        events   = '0;
        doReset();

        checkOutput("reset_rdata", rdata, 32'd0);
        checkOutput("reset_leds", 32'(leds), 32'd0);
        checkOutput("reset_duty", 32'(duty), 32'd0);
        checkOutput("reset_req", 32'(req), 32'd0);

        // Single-cycle register behaviour
        vecs.push_back(mkVec(1, 3'd2, 16'h0030, 32'h0000_002A, 0, 32'd0,  "led_store"));
        vecs.push_back(mkVec(1, 3'd1, 16'h0030, 32'd0,         1, 32'h2A, "led_rw"));
        vecs.push_back(mkVec(1, 3'd2, 16'h0030, 32'hFFFF_FFFF, 0, 32'd0,  "led_store_all"));
        vecs.push_back(mkVec(1, 3'd1, 16'h0030, 32'd0,         1, 32'h3F, "led_trunc"));
        vecs.push_back(mkVec(0, 3'd1, 16'h0028, 32'd0,         1, 32'h3F, "en_low_hold"));
        vecs.push_back(mkVec(1, 3'd6, 16'h0028, 32'd0,         1, 32'h3F, "nop_hold"));
        vecs.push_back(mkVec(1, 3'd1, 16'h0028, 32'd0,         1, 32'h2,  "switches"));
        vecs.push_back(mkVec(1, 3'd1, 16'h0040, 32'd0,         1, 32'h0,  "unmapped"));
        vecs.push_back(mkVec(1, 3'd1, 16'h0020, 32'd0,         1, 32'h1,  "fifo_empty"));
        vecs.push_back(mkVec(1, 3'd1, 16'h0024, 32'd0,         1, 32'h0,  "pop_empty"));
        vecs.push_back(mkVec(1, 3'd2, 16'h0100, 32'h0000_0123, 0, 32'd0,  "ch0_store"));
        vecs.push_back(mkVec(1, 3'd1, 16'h0100, 32'd0,         1, 32'h123, "ch0_duty"));
        vecs.push_back(mkVec(1, 3'd1, 16'h0104, 32'd0,         1, 32'h1,  "ch0_busy"));
        vecs.push_back(mkVec(1, 3'd2, 16'h0100, 32'h0000_0456, 0, 32'd0,  "ch0_store_busy"));
        vecs.push_back(mkVec(1, 3'd1, 16'h0100, 32'd0,         1, 32'h123, "ch0_duty_kept"));
        vecs.push_back(mkVec(1, 3'd1, 16'h0104, 32'd0,         1, 32'h3,  "ch0_err"));
        vecs.push_back(mkVec(1, 3'd2, 16'h0104, 32'h0000_0002, 0, 32'd0,  "ch0_err_clear"));
        vecs.push_back(mkVec(1, 3'd1, 16'h0104, 32'd0,         1, 32'h1,  "ch0_err_cleared"));
        vecs.push_back(mkVec(1, 3'd1, 16'h0110, 32'd0,         1, 32'h0,  "ch2_unmapped"));
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].e, vecs[i].sel, vecs[i].a, vecs[i].d);
            if (vecs[i].chk) checkOutput(vecs[i].name, rdata, vecs[i].exp);
        end

        // Cycle counter and clear
        doReset();
        repeat (100) tick();
        applyStimulus(1, 3'd1, 16'h0010, 32'd0);
        checks++;
        if (rdata < 32'd99 || rdata > 32'd101) begin
            fails++;
            $display("[TB] FAIL cycle_count: got %0d, expected 100 +/- 1", rdata);
        end
        applyStimulus(1, 3'd2, 16'h0018, 32'd0);
        applyStimulus(1, 3'd1, 16'h0010, 32'd0);
        checkOutput("cycle_after_clear", rdata, 32'd1);

        // Instruction counter: 5 accesses, 3 NOPs, then the load itself
        doReset();
        applyStimulus(1, 3'd1, 16'h0028, 32'd0);
        applyStimulus(1, 3'd2, 16'h0030, 32'd5);
        applyStimulus(1, 3'd1, 16'h0030, 32'd0);
        applyStimulus(1, 3'd2, 16'h0030, 32'd9);
        applyStimulus(1, 3'd1, 16'h0040, 32'd0);
        repeat (3) applyStimulus(1, 3'd6, 16'h0030, 32'd0);
        applyStimulus(1, 3'd1, 16'h0014, 32'd0);
        checkOutput("instr_count", rdata, 32'd6);

        // FIFO overflow and simultaneous push/pop on a full FIFO
        events = '0;
        doReset();
        for (int i = 0; i < 5; i++) begin
            events = 3'b001;
            tick();
            events = 3'b000;
            tick();
        end
        applyStimulus(1, 3'd1, 16'h0020, 32'd0);
        checkOutput("fifo_ovf_status", rdata, 32'h208);
        events = 3'b001;
        applyStimulus(1, 3'd1, 16'h0024, 32'd0);
        events = 3'b000;
        checkOutput("simul_pop_data", rdata, 32'd1);
        applyStimulus(1, 3'd1, 16'h0020, 32'd0);
        checkOutput("simul_status", rdata, 32'h208);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 3'd1, 16'h0024, 32'd0);
            checkOutput($sformatf("pop_%0d", i), rdata, 32'd1);
        end
        applyStimulus(1, 3'd1, 16'h0024, 32'd0);
        checkOutput("pop_after_drain", rdata, 32'd0);
        applyStimulus(1, 3'd1, 16'h0020, 32'd0);
        checkOutput("drained_status", rdata, 32'h201);
        applyStimulus(1, 3'd2, 16'h0020, 32'h200);
        applyStimulus(1, 3'd1, 16'h0020, 32'd0);
        checkOutput("ovf_cleared", rdata, 32'h001);

        // Handshake on channel 1
        doReset();
        applyStimulus(1, 3'd2, 16'h0108, 32'h0000_0ABC);
        checkOutput("ch1_duty", {20'd0, duty[23:12]}, 32'hABC);
        checkOutput("ch1_req_high", {31'd0, req[1]}, 32'd1);
        applyStimulus(1, 3'd2, 16'h0108, 32'h0000_0555);
        checkOutput("ch1_duty_stable", {20'd0, duty[23:12]}, 32'hABC);
        applyStimulus(1, 3'd1, 16'h010C, 32'd0);
        checkOutput("ch1_err_busy", rdata, 32'd3);
        ack[1] = 1'b1;
        tick();
        checkOutput("ch1_req_low", {31'd0, req[1]}, 32'd0);
        applyStimulus(1, 3'd1, 16'h010C, 32'd0);
        checkOutput("ch1_drop_busy", rdata, 32'd3);
        ack[1] = 1'b0;
        tick();
        applyStimulus(1, 3'd1, 16'h010C, 32'd0);
        checkOutput("ch1_idle", rdata, 32'd2);
        applyStimulus(1, 3'd2, 16'h010C, 32'd2);
        applyStimulus(1, 3'd1, 16'h010C, 32'd0);
        checkOutput("ch1_err_clear", rdata, 32'd0);

        // Reset mid-handshake
        doReset();
        applyStimulus(1, 3'd2, 16'h0100, 32'h0000_0123);
        checkOutput("ch0_req_before_rst", {31'd0, req[0]}, 32'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checkOutput("rst_req", 32'(req), 32'd0);
        checkOutput("rst_duty", 32'(duty), 32'd0);
        applyStimulus(1, 3'd1, 16'h0104, 32'd0);
        checkOutput("rst_busy", rdata, 32'd0);
        applyStimulus(1, 3'd2, 16'h0100, 32'h0000_0456);
        checkOutput("ch0_new_duty", {20'd0, duty[11:0]}, 32'h456);
        checkOutput("ch0_new_req", {31'd0, req[0]}, 32'd1);

        // Randomised run against the reference model
        events = '0;
        rst    = 1'b0;
        modelStep();
        tick();
        rst = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) != 0);
            en  = ($urandom_range(0, 3) != 0);
            v   = $urandom_range(0, 7);
            if (v < 3) mmap_sel = 3'd1;
            else if (v < 6) mmap_sel = 3'd2;
            else if (v == 6) mmap_sel = 3'd6;
            else mmap_sel = 3'($urandom_range(0, 7));
            v = $urandom_range(0, 16);
            addr     = (v < 14) ? addrPool[v] : 16'($urandom);
            wdata    = $urandom;
            switches = 2'($urandom);
            if ($urandom_range(0, 3) == 0) events = EV_W'($urandom);
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 2) == 0) ack[c] = ~ack[c];
            end
            modelStep();
            tick();
            checkOutput($sformatf("rand_rdata_%0d", n), rdata, mRdata);
            checkOutput($sformatf("rand_leds_%0d", n), 32'(leds), 32'(mLeds));
            checkOutput($sformatf("rand_duty_%0d", n), 32'(duty), {8'd0, mDuty[1], mDuty[0]});
            checkOutput($sformatf("rand_req_%0d", n), 32'(req), {30'd0, mReq[1], mReq[0]});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/mmio_hub.md
MMIO_HUB -- requirements
Module: mmio_hub

Interface
REQ-001 Parameter NUM_CH, default 2: number of duty-cycle output channels, legal range 1..8.
REQ-002 Parameter DW, default 12: duty-cycle width in bits, legal range 1..16.
REQ-003 Parameter FIFO_DEPTH, default 32: event FIFO depth, a power of two from 2 to 256.
REQ-004 Parameter EV_W, default 3: event input width, legal range 1..8.
REQ-005 Parameter LED_W, default 6: LED output width, legal range 1..16.
REQ-006 Port clk, in, 1: the single clock for the whole block; all logic is on its rising edge.
REQ-007 Port rst, in, 1: reset, synchronous and active-low.
REQ-008 Port en, in, 1: access qualifier; while low, the block ignores addr and mmap_sel.
REQ-009 Port addr, in, 16: byte offset of the access.
REQ-010 Port mmap_sel, in, 3: access type; LOAD=1, STORE=2, NOP=6, any other value means no access.
REQ-011 Port wdata, in, 32: store data.
REQ-012 Port rdata, out, 32: registered load data.
REQ-013 Port leds, out, LED_W: LED register.
REQ-014 Port switches, in, 2: switch inputs, already synchronised.
REQ-015 Port events, in, EV_W: button and event levels, already synchronised.
REQ-016 Port duty, out, NUM_CH*DW: per-channel duty values; channel c occupies bits [c*DW +: DW].
REQ-017 Port req, out, NUM_CH: per-channel four-phase request.
REQ-018 Port ack, in, NUM_CH: per-channel four-phase acknowledge, already synchronised.

Function
REQ-019 Address map:
- 0x10: cycle counter, R.
- 0x14: instruction counter, R.
- 0x18: counter clear, W.
- 0x20: FIFO status, R; {overflow, count, empty} in bits [9], [8:1], [0].
- 0x24: FIFO pop, R.
- 0x28: switches, R.
- 0x30: LEDs, R/W.
- 0x100+8c: duty of channel c, R/W.
- 0x104+8c: status of channel c, R/W; {err, busy} in bits [1:0].
REQ-020 A load with en=1 updates rdata on the next edge, giving a latency of 1; rdata holds its value otherwise; unmapped loads return 0.
REQ-021 The cycle counter increments every cycle and wraps at 2^32.
REQ-022 The instruction counter increments when en=1 and mmap_sel!=NOP, and wraps at 2^32.
REQ-023 A store to 0x18 zeroes both counters on that edge; the clear takes priority over the increment.
REQ-024 Event push occurs when any bit of events rises versus its value the previous cycle; the pushed data is the current events value.
REQ-025 A push to a full FIFO is dropped and sets the sticky overflow bit; a store to 0x20 with wdata[9]=1 clears it.
REQ-026 A load of 0x24 returns the head entry zero-extended and pops it; when the FIFO is empty, it returns 0 and does not pop.
REQ-027 Push and pop in the same cycle both take effect, including when the FIFO is full or empty; count is unchanged and no overflow is set.
REQ-028 Channel FSM states are IDLE, REQ and DROP; each channel has its own independent FSM.
REQ-029 In IDLE, a store to the channel's duty register latches wdata[DW-1:0] into duty, asserts req next cycle, and enters REQ.
REQ-030 In REQ, ack=1 deasserts req and enters DROP; in DROP, ack=0 returns the channel to IDLE.
REQ-031 busy=1 in REQ and DROP; duty is stable while busy.
REQ-032 A duty store while busy is discarded and sets the sticky err bit; a store to the status register with wdata[1]=1 clears it.
REQ-033 When a status-clear store coincides with a discarded duty store, err remains set.
REQ-034 An ack pulse seen in IDLE is ignored.
REQ-035 Loads have no side effects, except FIFO pop.

Reset
REQ-036 When rst=0 at an edge, the following are cleared: rdata=0, leds=0, duty=0, req=0, both counters=0, FIFO empty, overflow=0, all err=0, all FSMs IDLE, and the event history register = events.
REQ-037 Reset applied mid-handshake drops req immediately and discards the pending duty value.
REQ-038 Accesses presented while rst=0 are ignored.

Structure
REQ-039 Package mmio_pkg holds the mmap_sel codes, the address offsets, the channel stride of 8, and the channel FSM state enum.
REQ-040 The event FIFO is one sub-module, event_fifo, parametrised by width and depth, with count and full/empty outputs.
REQ-041 The channel FSM is generated NUM_CH times inside mmio_hub.

Verification
REQ-042 Counter clear: run 100 cycles with no access, then load 0x10, giving rdata=100±1; store 0x18, then the next load of 0x10 returns 1.
REQ-043 Instruction counting: 5 accesses and 3 NOP cycles, then load 0x14, giving rdata=5 plus the load itself.
REQ-044 FIFO overflow: with FIFO_DEPTH=4, produce 5 rising edges on events=3'b001.
- Load 0x20 returns count=4 and overflow=1.
- Four loads of 0x24 return 1 each; the fifth returns 0.
- Afterwards, empty=1.
REQ-045 Simultaneous push and pop: with the FIFO full, push and pop in the same cycle; count stays 4 and overflow is unchanged.
REQ-046 Handshake on channel 1: store 0x108 with 0xABC.
- duty[23:12]=0xABC and req[1]=1 one cycle later.
- A duty store before ack is dropped and sets err=1.
- ack=1 gives req=0; ack=0 returns the channel to busy=0.
REQ-047 Reset mid-handshake: with req[0]=1, pulse rst=0 for 1 cycle; req=0, duty=0 and busy=0, and the channel accepts a new store.
